// File: rtl/fifo_pop_ctrl_pkg.sv
// rtl/fifo_pop_ctrl_pkg.sv - shared FSM encodings and FIFO geometry for the FIFO read-side controller
package fifo_pop_ctrl_pkg;

  localparam int FIFO_DATA_WIDTH = 6;
  localparam int FIFO_DEPTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PAUSE = 2'd2,
    ST_BAD   = 2'd3
  } pop_state_e;

endpackage

// File: rtl/fifo_pop_ctrl_shadow_cnt.sv
// rtl/fifo_pop_ctrl_shadow_cnt.sv - shadow FIFO occupancy counter with saturation and sticky error
module fifo_shadow_cnt
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_mon,
  input  logic                 pop,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 error
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0] occ_next;
  logic                 err_next;

  // A push into a full FIFO is lost by the FIFO, so the count holds rather than wrapping.
  always_comb begin
    occ_next = occupancy;
    err_next = error;
    case ({push_mon, pop})
      2'b10: begin
        if (occupancy == FULL) err_next = 1'b1;
        else                   occ_next = occupancy + CNT_WIDTH'(1);
      end
      2'b01: begin
        if (occupancy == '0) err_next = 1'b1;
        else                 occ_next = occupancy - CNT_WIDTH'(1);
      end
      default: begin
        occ_next = occupancy;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      error     <= 1'b0;
    end else begin
      occupancy <= occ_next;
      error     <= err_next;
    end
  end

endmodule

// File: rtl/fifo_pop_ctrl.sv
// rtl/fifo_pop_ctrl.sv - FIFO read-side controller: pop FSM, 2-cycle capture pipeline, delivered-word counter
module fifo_pop_ctrl
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = FIFO_DATA_WIDTH,
  parameter int DEPTH        = FIFO_DEPTH,
  parameter int CNT_WIDTH    = 5,
  parameter int RD_CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    push_mon,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    dest_pausa,
  output logic                    pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic [CNT_WIDTH-1:0]    occupancy,
  output logic [RD_CNT_WIDTH-1:0] words_read,
  output logic [1:0]              state_out,
  output logic                    error_out
);

  pop_state_e state;
  pop_state_e state_next;
  logic       rd_pend;
  logic       occ_zero;
  logic       occ_one;

  assign occ_zero  = (occupancy == '0);
  assign occ_one   = (occupancy == CNT_WIDTH'(1));
  assign state_out = state;

  // Back-pressure gates pop in the same cycle; the shadow count avoids the FIFO's lagging flags.
  assign pop = (state == ST_DRAIN) && !occ_zero && !dest_pausa;

  fifo_shadow_cnt #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .push_mon  (push_mon),
    .pop       (pop),
    .occupancy (occupancy),
    .error     (error_out)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable && !occ_zero) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dest_pausa)                         state_next = ST_PAUSE;
        else if (!enable)                       state_next = ST_IDLE;
        else if (occ_zero && !push_mon)         state_next = ST_IDLE;
        else if (occ_one && pop && !push_mon)   state_next = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!enable)          state_next = ST_IDLE;
        else if (!dest_pausa) state_next = ST_DRAIN;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // rd_pend marks that fifo_data carries a popped word this cycle; words already popped
  // are delivered even after the FSM leaves DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_pend    <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      words_read <= '0;
    end else begin
      state     <= state_next;
      rd_pend   <= pop;
      valid_out <= rd_pend;
      if (rd_pend) begin
        data_out   <= fifo_data;
        words_read <= words_read + RD_CNT_WIDTH'(1);
      end
    end
  end

endmodule
